timer_mode_controller: RTL and testbench

Parametrised, sequential successor to the combinational mode/time controller. It latches an operating Mode and a preset time, then counts the time down at a prescaled tick rate. It drives the downstream counter's input and enable and reports run and done status. It adds start/pause/resume/abort control, a prescaler and a done pulse. It sits between the user-input decode logic and the display/counter datapath.

---
 rtl/timer_ctrl_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 37 +++
 rtl/timer_mode_controller.sv | 141 ++++++++++++++
 tb/tb_timer_mode_controller.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared types for the timer mode controller: FSM state encoding and the
// "mode off" value.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MODE_OFF = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while en is low so a paused countdown resumes in phase.
module tick_prescaler #(
  parameter int TICK_DIV = 1000,
  parameter int DIV_W    = $clog2(TICK_DIV) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_mode_controller.sv
// Latches a mode and preset time, then counts the time down at the prescaled
// tick rate with start/pause/resume/abort control. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for a valid Start; outputs quiet
// RUN   | counting down; CounterInput shows latched mode
// PAUSE | countdown and prescaler frozen; Start resumes
// DONE  | countdown reached 0; Start restarts, Abort returns to IDLE
module timer_mode_controller
  import timer_ctrl_pkg::*;
#(
  parameter int MODE_W   = 4,
  parameter int TIME_W   = 12,
  parameter int TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] Mode,
  input  logic [TIME_W-1:0] PresentTime,
  input  logic              Start,
  input  logic              Pause,
  input  logic              Abort,
  output logic [MODE_W-1:0] CounterInput,
  output logic              CounterEnable,
  output logic              isRunning,
  output logic              isPaused,
  output logic              Done,
  output logic [TIME_W-1:0] RemainingTime
);

  localparam int DIV_W = $clog2(TICK_DIV) + 1;

  state_e            state_q, state_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [MODE_W-1:0] ci_q, ci_d;
  logic              ce_q, ce_d;
  logic              run_q, run_d;
  logic              pau_q, pau_d;
  logic              done_q, done_d;

  logic presc_en, presc_clr, tick;
  logic start_ok;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  assign start_ok = Start && (Mode != MODE_W'(MODE_OFF)) && (PresentTime != '0);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    ce_d      = 1'b0;
    done_d    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;

    if (Abort) begin
      state_d   = IDLE;
      mode_d    = MODE_W'(MODE_OFF);
      rem_d     = '0;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            state_d   = RUN;
            mode_d    = Mode;
            rem_d     = PresentTime;
            presc_clr = 1'b1;
          end
        end
        RUN: begin
          if (Pause) begin
            state_d = PAUSE;
          end else begin
            presc_en = 1'b1;
            // Gate on nonzero so the count can never wrap below 0.
            if (tick && (rem_q != '0)) begin
              rem_d = rem_q - 1'b1;
              ce_d  = 1'b1;
              if (rem_q == TIME_W'(1)) begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (Start && !Pause) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    run_d = (state_d == RUN);
    pau_d = (state_d == PAUSE);
    ci_d  = (state_d == RUN || state_d == PAUSE) ? mode_d : MODE_W'(MODE_OFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      ci_q    <= '0;
      ce_q    <= 1'b0;
      run_q   <= 1'b0;
      pau_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      ci_q    <= ci_d;
      ce_q    <= ce_d;
      run_q   <= run_d;
      pau_q   <= pau_d;
      done_q  <= done_d;
    end
  end

  assign CounterInput  = ci_q;
  assign CounterEnable = ce_q;
  assign isRunning     = run_q;
  assign isPaused      = pau_q;
  assign Done          = done_q;
  assign RemainingTime = rem_q;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Bench for timer_mode_controller: two instances (TICK_DIV=4 and 1) share
// stimulus and are checked every cycle against a behavioural model.
module tb_timer_mode_controller;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int st;
    int rem;
    int ph;
    int mode;
    int ce;
    int dn;
  } mdl_t;

  typedef struct {
    bit rst; int mode; int pt; bit start; bit pause; bit abort;
    int run; int pau; int rem; int ci; int ce; int dn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mode;
  logic [11:0] pt;
  logic        start, pause, abort;

  logic [3:0]  ci4, ci1;
  logic        ce4, ce1, run4, run1, pau4, pau1, dn4, dn1;
  logic [11:0] rem4, rem1;

  int   nerr = 0;
  int   nchk = 0;
  mdl_t m4, m1;
  vec_t tbl[$];

  always #5 clk = ~clk;

  timer_mode_controller #(.MODE_W(4), .TIME_W(12), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Mode(mode), .PresentTime(pt),
    .Start(start), .Pause(pause), .Abort(abort),
    .CounterInput(ci4), .CounterEnable(ce4), .isRunning(run4),
    .isPaused(pau4), .Done(dn4), .RemainingTime(rem4)
  );

  timer_mode_controller #(.MODE_W(4), .TIME_W(12), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Mode(mode), .PresentTime(pt),
    .Start(start), .Pause(pause), .Abort(abort),
    .CounterInput(ci1), .CounterEnable(ce1), .isRunning(run1),
    .isPaused(pau1), .Done(dn1), .RemainingTime(rem1)
  );

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = M_IDLE; r.rem = 0; r.ph = 0; r.mode = 0; r.ce = 0; r.dn = 0;
    return r;
  endfunction

  // One clock of the controller's rules, in terms of elapsed run cycles.
  function automatic mdl_t mstep(mdl_t m, int div, bit r, int md, int t,
                                 bit s, bit p, bit a);
    mdl_t n = m;
    n.ce = 0;
    n.dn = 0;
    if (!r) return mreset();
    if (a) begin
      n = mreset();
      return n;
    end
    if (m.st == M_IDLE || m.st == M_DONE) begin
      if (s && md != 0 && t != 0) begin
        n.st = M_RUN; n.mode = md; n.rem = t; n.ph = 0;
      end
    end else if (m.st == M_RUN) begin
      if (p) n.st = M_PAUSE;
      else begin
        n.ph = (m.ph + 1) % div;
        if (n.ph == 0 && m.rem > 0) begin
          n.rem = m.rem - 1;
          n.ce  = 1;
          if (n.rem == 0) begin
            n.st = M_DONE;
            n.dn = 1;
          end
        end
      end
    end else if (m.st == M_PAUSE) begin
      if (s && !p) n.st = M_RUN;
    end
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, mdl_t m, logic run, logic pau,
                          logic [11:0] rem, logic [3:0] ci, logic ce, logic dn);
    int eci;
    eci = (m.st == M_RUN || m.st == M_PAUSE) ? m.mode : 0;
    chk({tag, ".isRunning"},     int'(run), int'(m.st == M_RUN));
    chk({tag, ".isPaused"},      int'(pau), int'(m.st == M_PAUSE));
    chk({tag, ".RemainingTime"}, int'(rem), m.rem);
    chk({tag, ".CounterInput"},  int'(ci),  eci);
    chk({tag, ".CounterEnable"}, int'(ce),  m.ce);
    chk({tag, ".Done"},          int'(dn),  m.dn);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    m4 = mstep(m4, 4, rst_n, int'(mode), int'(pt), start, pause, abort);
    m1 = mstep(m1, 1, rst_n, int'(mode), int'(pt), start, pause, abort);
    chk_outs("div4", m4, run4, pau4, rem4, ci4, ce4, dn4);
    chk_outs("div1", m1, run1, pau1, rem1, ci1, ce1, dn1);
  endtask

  task automatic add(bit r, int md, int t, bit s, bit p, bit a,
                     int run, int pau, int rem, int ci, int ce, int dn);
    vec_t v;
    v.rst = r; v.mode = md; v.pt = t; v.start = s; v.pause = p; v.abort = a;
    v.run = run; v.pau = pau; v.rem = rem; v.ci = ci; v.ce = ce; v.dn = dn;
    tbl.push_back(v);
  endtask

  initial begin
    int n, nce, ndn;
    rst_n = 1'b0; mode = '0; pt = '0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    m4 = mreset();
    m1 = mreset();

    //  rst md   pt st pa ab | run pau rem ci ce dn   (TICK_DIV=4 instance)
    add(0, 2,    3, 1, 0, 0,   0,  0,  0, 0, 0, 0);
    add(0, 2,    3, 1, 0, 0,   0,  0,  0, 0, 0, 0);
    add(0, 2,    3, 1, 0, 0,   0,  0,  0, 0, 0, 0);
    add(1, 2,    3, 1, 0, 0,   1,  0,  3, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  3, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  3, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  3, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  2, 2, 1, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  2, 2, 0, 0);
    add(1, 2,    3, 0, 1, 0,   0,  1,  2, 2, 0, 0);
    add(1, 2,    3, 1, 1, 0,   0,  1,  2, 2, 0, 0);
    add(1, 2,    3, 1, 0, 0,   1,  0,  2, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  2, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  2, 2, 0, 0);
    add(1, 2,    3, 0, 0, 0,   1,  0,  1, 2, 1, 0);
    add(1, 2,    3, 0, 1, 1,   0,  0,  0, 0, 0, 0);
    add(1, 0, 1024, 1, 0, 0,   0,  0,  0, 0, 0, 0);
    add(1, 10,   0, 1, 0, 0,   0,  0,  0, 0, 0, 0);
    add(1, 1,    1, 1, 0, 0,   1,  0,  1, 1, 0, 0);
    add(1, 1,    1, 0, 0, 0,   1,  0,  1, 1, 0, 0);
    add(1, 1,    1, 0, 0, 0,   1,  0,  1, 1, 0, 0);
    add(1, 1,    1, 0, 0, 0,   1,  0,  1, 1, 0, 0);
    add(1, 1,    1, 0, 0, 0,   0,  0,  0, 0, 1, 1);
    add(1, 1,    1, 0, 0, 0,   0,  0,  0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; mode = 4'(tbl[i].mode); pt = 12'(tbl[i].pt);
      start = tbl[i].start; pause = tbl[i].pause; abort = tbl[i].abort;
      cycle();
      chk($sformatf("tbl[%0d].isRunning", i),     int'(run4), tbl[i].run);
      chk($sformatf("tbl[%0d].isPaused", i),      int'(pau4), tbl[i].pau);
      chk($sformatf("tbl[%0d].RemainingTime", i), int'(rem4), tbl[i].rem);
      chk($sformatf("tbl[%0d].CounterInput", i),  int'(ci4),  tbl[i].ci);
      chk($sformatf("tbl[%0d].CounterEnable", i), int'(ce4),  tbl[i].ce);
      chk($sformatf("tbl[%0d].Done", i),          int'(dn4),  tbl[i].dn);
    end
    start = 1'b0;

    // Basic countdown from DONE: 3 ticks every 4 clocks, single Done.
    mode = 4'b0010; pt = 12'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0; nce = 0; ndn = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n++;
      if (ce4) begin
        chk("seqA.rem_at_tick", int'(rem4), 2 - nce);
        nce++;
      end
      if (dn4) begin
        ndn++;
        chk("seqA.done_latency", n, 12);
      end
    end
    chk("seqA.ticks", nce, 3);
    chk("seqA.dones", ndn, 1);
    chk("seqA.running_after", int'(run4), 0);

    // Pause mid-prescale, hold, resume keeping prescaler phase.
    mode = 4'd3; pt = 12'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0; nce = 0;
    while (nce < 2 && n < 40) begin
      cycle();
      n++;
      if (ce4) nce++;
    end
    chk("seqB.two_ticks", nce, 2);
    cycle();
    cycle();
    pause = 1'b1; mode = 4'd7; pt = 12'd99;
    cycle();
    pause = 1'b0;
    chk("seqB.paused", int'(pau4), 1);
    nce = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (ce4) nce++;
    end
    chk("seqB.ce_in_pause", nce, 0);
    chk("seqB.rem_hold", int'(rem4), 3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("seqB.resumed", int'(run4), 1);
    chk("seqB.mode_kept", int'(ci4), 3);
    n = 0; nce = 0;
    while (!dn4 && n < 40) begin
      cycle();
      n++;
      if (ce4) nce++;
    end
    chk("seqB.resume_to_done", n, 10);
    chk("seqB.ticks_after_resume", nce, 3);

    // Abort at RemainingTime=7, then Abort together with Pause.
    mode = 4'd5; pt = 12'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (rem4 != 12'd7 && n < 40) begin
      cycle();
      n++;
    end
    chk("seqC.reach7", n, 8);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("seqC.abort_run", int'(run4), 0);
    chk("seqC.abort_rem", int'(rem4), 0);
    chk("seqC.abort_ci", int'(ci4), 0);
    chk("seqC.abort_done", int'(dn4), 0);
    start = 1'b1;
    cycle();
    start = 1'b0; pause = 1'b1;
    cycle();
    chk("seqC.paused", int'(pau4), 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0; pause = 1'b0;
    chk("seqC.abort_pause_pau", int'(pau4), 0);
    chk("seqC.abort_pause_run", int'(run4), 0);
    chk("seqC.abort_pause_rem", int'(rem4), 0);

    // TICK_DIV=1 full-range countdown; Mode changes mid-run are ignored.
    mode = 4'hF; pt = 12'hFFF; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (!dn1 && n < 5000) begin
      if (n == 100) begin
        mode = 4'd3; pt = 12'd5;
      end
      cycle();
      n++;
      if (n == 2000) chk("seqD.ci_hold", int'(ci1), 15);
    end
    chk("seqD.latency", n, 4095);
    chk("seqD.rem_zero", int'(rem1), 0);
    chk("seqD.running_after", int'(run1), 0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      abort = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 3) == 0);
      mode  = 4'($urandom_range(0, 3));
      pt    = 12'($urandom_range(0, 12));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
